vita49_pack64: RTL and testbench

Downstream neighbour of the VITA-49 timestamp trigger gate: consumes the gated 32-bit sample AXI-Stream it emits and frames it into VITA-49 IF-data packets (header, stream ID, integer and fractional timestamp, fixed-length payload). The timestamp of each packet is the tsi/tsf value from the timing unit on the cycle the first payload sample is presented. Output feeds the DMA / Ethernet egress stream.

---
 rtl/vita49_pack64.sv | 201 ++++++++++++++++++++
 tb/tb_vita49_pack64.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/vita49_pack64.sv
`default_nettype none
// ============================================================================
//  Module      : vita49_pack64
//  Description : Frames a gated 32-bit sample AXI-Stream into VITA-49 IF-data
//                packets: header, stream ID, integer timestamp, fractional
//                timestamp (hi/lo) and a fixed-length payload. The timestamp
//                is the tsi/tsf value present when the first payload sample is
//                offered while idle.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    AXIS_ACLK / AXIS_ARESET      : clock, synchronous active-high reset
//    S_AXIS_*                     : sample stream in (TLAST ignored)
//    M_AXIS_*                     : packet stream out
//    en                           : packetizer enable, checked between packets
//    stream_id, payload_len       : per-packet framing controls
//    tsi, tsf                     : timing-unit timestamp
//    pkt_count                    : packets completed since reset (wraps)
//    busy                         : a packet is in progress
// ============================================================================
module vita49_pack64 #(
    parameter int         C_AXIS_TDATA_NUM_BYTES = 4,
    parameter logic [3:0] C_PKT_TYPE             = 4'b0001,
    parameter logic [1:0] C_TSI_TYPE             = 2'b01,
    parameter logic [1:0] C_TSF_TYPE             = 2'b10
) (
    input  logic                                  AXIS_ACLK,
    input  logic                                  AXIS_ARESET,
    input  logic [C_AXIS_TDATA_NUM_BYTES*8-1:0]   S_AXIS_TDATA,
    input  logic [C_AXIS_TDATA_NUM_BYTES-1:0]     S_AXIS_TSTRB,
    input  logic                                  S_AXIS_TLAST,
    input  logic                                  S_AXIS_TVALID,
    output logic                                  S_AXIS_TREADY,
    output logic [C_AXIS_TDATA_NUM_BYTES*8-1:0]   M_AXIS_TDATA,
    output logic [C_AXIS_TDATA_NUM_BYTES-1:0]     M_AXIS_TSTRB,
    output logic                                  M_AXIS_TLAST,
    output logic                                  M_AXIS_TVALID,
    input  logic                                  M_AXIS_TREADY,
    input  logic                                  en,
    input  logic [31:0]                           stream_id,
    input  logic [15:0]                           payload_len,
    input  logic [31:0]                           tsi,
    input  logic [63:0]                           tsf,
    output logic [31:0]                           pkt_count,
    output logic                                  busy
);

    localparam logic [15:0] C_MAX_LEN  = 16'd65530;  // keeps size field within 16 bits
    localparam logic [15:0] C_HDR_WDS  = 16'd5;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR     = 3'd1,
        ST_SID     = 3'd2,
        ST_TSI     = 3'd3,
        ST_TSF_HI  = 3'd4,
        ST_TSF_LO  = 3'd5,
        ST_PAYLOAD = 3'd6
    } state_t;

    state_t       state_q, state_d;
    logic [3:0]   seq_q, seq_d;
    logic [31:0]  pkt_count_q, pkt_count_d;
    logic [15:0]  len_q, len_d;
    logic [15:0]  cnt_q, cnt_d;
    logic [31:0]  sid_q, sid_d;
    logic [31:0]  tsi_q, tsi_d;
    logic [63:0]  tsf_q, tsf_d;

    logic [15:0]  w_len_eff;
    logic [15:0]  w_hdr_size;
    logic [31:0]  w_hdr_word;
    logic         w_last;

    // TLAST from the sample stream plays no part in framing.
    logic         w_unused_tlast;
    assign w_unused_tlast = S_AXIS_TLAST;

    // A zero length would never produce TLAST, so it is promoted to one word.
    always_comb begin
        w_len_eff = payload_len;
        if (payload_len == 16'd0) begin
            w_len_eff = 16'd1;
        end else if (payload_len > C_MAX_LEN) begin
            w_len_eff = C_MAX_LEN;
        end
    end

    assign w_hdr_size = len_q + C_HDR_WDS;
    assign w_hdr_word = {C_PKT_TYPE, 1'b0, 1'b0, 2'b00, C_TSI_TYPE, C_TSF_TYPE,
                         seq_q, w_hdr_size};
    assign w_last     = (cnt_q == (len_q - 16'd1));

    always_comb begin
        state_d       = state_q;
        seq_d         = seq_q;
        pkt_count_d   = pkt_count_q;
        len_d         = len_q;
        cnt_d         = cnt_q;
        sid_d         = sid_q;
        tsi_d         = tsi_q;
        tsf_d         = tsf_q;
        S_AXIS_TREADY = 1'b0;
        M_AXIS_TDATA  = '0;
        M_AXIS_TSTRB  = '0;
        M_AXIS_TLAST  = 1'b0;
        M_AXIS_TVALID = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // The triggering sample is not consumed here; it is passed
                // through once the header has gone out.
                if (en && S_AXIS_TVALID) begin
                    len_d   = w_len_eff;
                    sid_d   = stream_id;
                    tsi_d   = tsi;
                    tsf_d   = tsf;
                    cnt_d   = 16'd0;
                    state_d = ST_HDR;
                end
            end
            ST_HDR: begin
                M_AXIS_TVALID = 1'b1;
                M_AXIS_TSTRB  = '1;
                M_AXIS_TDATA  = w_hdr_word;
                if (M_AXIS_TREADY) state_d = ST_SID;
            end
            ST_SID: begin
                M_AXIS_TVALID = 1'b1;
                M_AXIS_TSTRB  = '1;
                M_AXIS_TDATA  = sid_q;
                if (M_AXIS_TREADY) state_d = ST_TSI;
            end
            ST_TSI: begin
                M_AXIS_TVALID = 1'b1;
                M_AXIS_TSTRB  = '1;
                M_AXIS_TDATA  = tsi_q;
                if (M_AXIS_TREADY) state_d = ST_TSF_HI;
            end
            ST_TSF_HI: begin
                M_AXIS_TVALID = 1'b1;
                M_AXIS_TSTRB  = '1;
                M_AXIS_TDATA  = tsf_q[63:32];
                if (M_AXIS_TREADY) state_d = ST_TSF_LO;
            end
            ST_TSF_LO: begin
                M_AXIS_TVALID = 1'b1;
                M_AXIS_TSTRB  = '1;
                M_AXIS_TDATA  = tsf_q[31:0];
                if (M_AXIS_TREADY) state_d = ST_PAYLOAD;
            end
            ST_PAYLOAD: begin
                M_AXIS_TDATA  = S_AXIS_TDATA;
                M_AXIS_TSTRB  = S_AXIS_TSTRB;
                M_AXIS_TVALID = S_AXIS_TVALID;
                M_AXIS_TLAST  = w_last;
                S_AXIS_TREADY = M_AXIS_TREADY;
                if (S_AXIS_TVALID && M_AXIS_TREADY) begin
                    if (w_last) begin
                        seq_d       = seq_q + 4'd1;
                        pkt_count_d = pkt_count_q + 32'd1;
                        cnt_d       = 16'd0;
                        state_d     = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge AXIS_ACLK) begin
        if (AXIS_ARESET) begin
            state_q     <= ST_IDLE;
            seq_q       <= 4'd0;
            pkt_count_q <= 32'd0;
            len_q       <= 16'd1;
            cnt_q       <= 16'd0;
            sid_q       <= 32'd0;
            tsi_q       <= 32'd0;
            tsf_q       <= 64'd0;
        end else begin
            state_q     <= state_d;
            seq_q       <= seq_d;
            pkt_count_q <= pkt_count_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            sid_q       <= sid_d;
            tsi_q       <= tsi_d;
            tsf_q       <= tsf_d;
        end
    end

    assign pkt_count = pkt_count_q;
    assign busy      = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_vita49_pack64.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vita49_pack64
//  Description : Self-checking bench for vita49_pack64. Packet vectors hold
//                hand-computed header words and payload lengths; the output
//                stream is checked word by word, plus directed sequences for
//                reset mid-packet, sequence wrap and the maximum length.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vita49_pack64;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] s_data;
    logic [3:0]  s_strb;
    logic        s_last;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] m_data;
    logic [3:0]  m_strb;
    logic        m_last;
    logic        m_valid;
    logic        m_ready;
    logic        en;
    logic [31:0] stream_id;
    logic [15:0] payload_len;
    logic [31:0] tsi;
    logic [63:0] tsf;
    logic [31:0] pkt_count;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vita49_pack64 dut (
        .AXIS_ACLK     (clk),
        .AXIS_ARESET   (rst),
        .S_AXIS_TDATA  (s_data),
        .S_AXIS_TSTRB  (s_strb),
        .S_AXIS_TLAST  (s_last),
        .S_AXIS_TVALID (s_valid),
        .S_AXIS_TREADY (s_ready),
        .M_AXIS_TDATA  (m_data),
        .M_AXIS_TSTRB  (m_strb),
        .M_AXIS_TLAST  (m_last),
        .M_AXIS_TVALID (m_valid),
        .M_AXIS_TREADY (m_ready),
        .en            (en),
        .stream_id     (stream_id),
        .payload_len   (payload_len),
        .tsi           (tsi),
        .tsf           (tsf),
        .pkt_count     (pkt_count),
        .busy          (busy)
    );

    typedef struct {
        logic [15:0] len;
        logic [31:0] sid;
        logic [31:0] tsi;
        logic [63:0] tsf;
        logic [31:0] base;
        bit          bp;        // random downstream backpressure
        bit          drop_en;   // drop en during payload word 2
        logic [31:0] exp_hdr;
        int          exp_n;     // expected payload words
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input vec_t v, input int idx);
        case (idx)
            0:       return v.exp_hdr;
            1:       return v.sid;
            2:       return v.tsi;
            3:       return v.tsf[63:32];
            4:       return v.tsf[31:0];
            default: return v.base + 32'(idx - 4);
        endcase
    endfunction

    // Offers one packet's worth of samples and checks every output word.
    task automatic run_pkt(input vec_t v);
        int          idx     = 0;
        int          k       = 0;
        int          cyc     = 0;
        int          first_v = -1;
        int          total   = 5 + v.exp_n;
        bit          stalled = 0;
        bit          s_xfer;
        logic [31:0] held    = '0;
        @(posedge clk); #1;
        en          = 1'b1;
        payload_len = v.len;
        stream_id   = v.sid;
        tsi         = v.tsi;
        tsf         = v.tsf;
        s_valid     = 1'b1;
        s_strb      = 4'hF;
        s_data      = v.base + 32'd1;
        s_last      = 1'b1;
        while (idx < total && cyc < total * 8 + 20) begin
            if (cyc == 1) begin
                // Controls changing after the latch must not reach this packet.
                payload_len = ~v.len;
                stream_id   = ~v.sid;
                tsi         = ~v.tsi;
                tsf         = ~v.tsf;
            end
            m_ready = v.bp ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (m_valid && first_v < 0) begin
                first_v = cyc;
                check("first_valid_latency", 64'(cyc), 64'd1);
            end
            if (stalled) check("stall_hold", {31'd0, m_valid, m_data}, {31'd0, 1'b1, held});
            if (idx < 5 && m_valid) check("s_ready_in_header", {63'd0, s_ready}, 64'd0);
            if (m_valid && m_ready) begin
                check("word", {28'd0, m_strb, m_data}, {28'd0, 4'hF, exp_word(v, idx)});
                check("tlast", {63'd0, m_last}, {63'd0, (idx == total - 1)});
                idx++;
                stalled = 0;
                if (v.drop_en && idx == 6) en = 1'b0;
            end else if (m_valid) begin
                stalled = 1;
                held    = m_data;
            end else begin
                stalled = 0;
            end
            s_xfer = s_valid && s_ready;
            @(posedge clk); #1;
            if (s_xfer) begin
                k++;
                s_data = v.base + 32'(k + 1);
                s_last = (k % 3 == 0);
            end
            cyc++;
        end
        if (idx < total) check("pkt_timeout", 64'(idx), 64'(total));
        s_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en = 1'b0;
        s_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    vec_t vecs[5];
    vec_t v;

    initial begin
        rst = 1'b1; en = 1'b0; s_valid = 1'b0; s_data = '0; s_strb = '0; s_last = 1'b0;
        m_ready = 1'b0; stream_id = '0; payload_len = '0; tsi = '0; tsf = '0;

        vecs[0] = '{len:16'd4, sid:32'hCAFE_0001, tsi:32'd100, tsf:64'h0000_0001_0000_0002,
                    base:32'd0, bp:0, drop_en:0, exp_hdr:32'h1060_0009, exp_n:4};
        vecs[1] = '{len:16'd7, sid:32'h1234_5678, tsi:32'hDEAD_BEEF, tsf:64'h0123_4567_89AB_CDEF,
                    base:32'hA000_0000, bp:1, drop_en:0, exp_hdr:32'h1061_000C, exp_n:7};
        vecs[2] = '{len:16'd0, sid:32'h0000_0BAD, tsi:32'd7, tsf:64'd9,
                    base:32'hB000_0000, bp:0, drop_en:0, exp_hdr:32'h1062_0006, exp_n:1};
        vecs[3] = '{len:16'd3, sid:32'h8765_4321, tsi:32'd55, tsf:64'hFFFF_0000_0000_FFFF,
                    base:32'hC000_0000, bp:1, drop_en:0, exp_hdr:32'h1063_0008, exp_n:3};
        vecs[4] = '{len:16'd4, sid:32'h0000_0044, tsi:32'd44, tsf:64'd44,
                    base:32'hD000_0000, bp:0, drop_en:1, exp_hdr:32'h1064_0009, exp_n:4};

        repeat (3) @(posedge clk);
        #1; rst = 1'b0; #1;
        check("rst_m_valid",   {63'd0, m_valid}, 64'd0);
        check("rst_s_ready",   {63'd0, s_ready}, 64'd0);
        check("rst_busy",      {63'd0, busy},    64'd0);
        check("rst_pkt_count", {32'd0, pkt_count}, 64'd0);

        for (int i = 0; i < 5; i++) begin
            run_pkt(vecs[i]);
            check("pkt_count_table", {32'd0, pkt_count}, 64'(i + 1));
        end

        // After en was dropped, a waiting sample must not be accepted.
        s_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #2;
            check("en_off_s_ready", {63'd0, s_ready}, 64'd0);
            check("en_off_busy",    {63'd0, busy},    64'd0);
        end
        s_valid = 1'b0;

        // Reset while the TSI word is on the bus.
        @(posedge clk); #1;
        en = 1'b1; payload_len = 16'd2; stream_id = 32'h5555_AAAA; tsi = 32'h0000_0777;
        tsf = 64'd3; s_valid = 1'b1; s_data = 32'd1; s_strb = 4'hF; m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("tsi_state_word", {31'd0, m_valid, m_data}, {31'd0, 1'b1, 32'h0000_0777});
        rst = 1'b1; en = 1'b0; s_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; #1;
        check("abort_m_valid",   {63'd0, m_valid}, 64'd0);
        check("abort_busy",      {63'd0, busy},    64'd0);
        check("abort_pkt_count", {32'd0, pkt_count}, 64'd0);
        v = '{len:16'd2, sid:32'h0000_1111, tsi:32'd11, tsf:64'd12,
              base:32'hE000_0000, bp:0, drop_en:0, exp_hdr:32'h1060_0007, exp_n:2};
        run_pkt(v);

        // Sequence field wraps after 16 packets.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            v = '{len:16'd1, sid:32'(i), tsi:32'(i), tsf:64'(i), base:32'(i * 16),
                  bp:(i % 2 == 1), drop_en:0,
                  exp_hdr:(32'h1060_0006 | (32'(i % 16) << 16)), exp_n:1};
            run_pkt(v);
        end
        check("pkt_count_wrap", {32'd0, pkt_count}, 64'd17);

        // Oversized request is clamped to the largest size the field can carry.
        v = '{len:16'hFFFF, sid:32'hFACE_0000, tsi:32'd1, tsf:64'd2,
              base:32'h1000_0000, bp:0, drop_en:0, exp_hdr:32'h1061_FFFF, exp_n:65530};
        run_pkt(v);
        check("pkt_count_max", {32'd0, pkt_count}, 64'd18);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
